// File: rtl/key_conditioner.sv
// Key and start-button conditioner: synchronizes and debounces four colour keys and a start
// button, and turns accepted presses into one-cycle events for the game core.
module key_conditioner #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_k,
    input  logic       raw_start,
    output logic [3:0] k,
    output logic       start,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        FIRE,
        WAIT_REL,
        REL_DEB
    } state_t;

    localparam logic [7:0] DEB = 8'(DEB_CYCLES);

    logic [3:0] meta_k, sync_k;
    logic       meta_s, sync_s;
    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] code, code_nx;
    logic [7:0] scnt;
    logic       start_lvl;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_k <= 4'b0;
            sync_k <= 4'b0;
            meta_s <= 1'b0;
            sync_s <= 1'b0;
        end else begin
            meta_k <= raw_k;
            sync_k <= meta_k;
            meta_s <= raw_start;
            sync_s <= meta_s;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_nx = state;
        cnt_nx   = cnt;
        code_nx  = code;
        case (state)
            IDLE: begin
                if (is_onehot(sync_k)) begin
                    code_nx  = sync_k;
                    cnt_nx   = 8'd1;
                    state_nx = (DEB == 8'd1) ? FIRE : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync_k == code) begin
                    cnt_nx = cnt + 8'd1;
                    if (cnt_nx == DEB) state_nx = FIRE;
                end else if (is_onehot(sync_k)) begin
                    code_nx = sync_k;
                    cnt_nx  = 8'd1;
                end else begin
                    state_nx = IDLE;
                end
            end
            FIRE: state_nx = WAIT_REL;
            WAIT_REL: begin
                if (sync_k == 4'b0) begin
                    cnt_nx   = 8'd1;
                    state_nx = (DEB == 8'd1) ? IDLE : REL_DEB;
                end
            end
            REL_DEB: begin
                if (sync_k == 4'b0) begin
                    cnt_nx = cnt + 8'd1;
                    if (cnt_nx == DEB) state_nx = IDLE;
                end else begin
                    state_nx = WAIT_REL;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // k and busy are registered from the next-state decode so they align with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            code  <= 4'b0;
            k     <= 4'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            code  <= code_nx;
            k     <= (state_nx == FIRE) ? code_nx : 4'b0;
            busy  <= (state_nx != IDLE);
        end
    end

    // Start channel: the counter tracks consecutive samples that disagree with the accepted level.
    always_ff @(posedge clock) begin
        if (reset) begin
            scnt      <= 8'd0;
            start_lvl <= 1'b0;
            start     <= 1'b0;
        end else begin
            start <= 1'b0;
            if (sync_s == start_lvl) begin
                scnt <= 8'd0;
            end else if (scnt + 8'd1 == DEB) begin
                scnt      <= 8'd0;
                start_lvl <= sync_s;
                start     <= sync_s;
            end else begin
                scnt <= scnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: run-length reference model compared every cycle,
// directed scenarios with hand-computed timing, then randomized bouncing stimulus.
module tb_key_conditioner;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] raw_k = 4'b0;
    logic       raw_start = 1'b0;
    logic [3:0] k;
    logic       start;
    logic       busy;

    key_conditioner #(.DEB_CYCLES(DEB)) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_k     (raw_k),
        .raw_start (raw_start),
        .k         (k),
        .start     (start),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit onehot(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    // Reference model: two-sample delay, then rules on run lengths of identical samples.
    int         cyc = 0;
    logic [3:0] m_s1 = 4'b0, m_s2 = 4'b0;
    logic       m_t1 = 1'b0, m_t2 = 1'b0;
    logic [3:0] kval = 4'b0;
    int         krun = 0;
    bit         armed = 1'b1;
    bit         blind = 1'b0;
    int         zrun = 0;
    logic       sval = 1'b0;
    int         srun = 0;
    logic       lvl = 1'b0;
    logic [3:0] exp_k = 4'b0;
    logic       exp_start = 1'b0;
    logic       exp_busy = 1'b0;

    always @(posedge clock) begin
        logic [3:0] sk;
        logic       ss;
        cyc++;
        if (reset) begin
            m_s1 = 4'b0; m_s2 = 4'b0; m_t1 = 1'b0; m_t2 = 1'b0;
            kval = 4'b0; krun = 0; armed = 1'b1; blind = 1'b0; zrun = 0;
            sval = 1'b0; srun = 0; lvl = 1'b0;
            exp_k = 4'b0; exp_start = 1'b0; exp_busy = 1'b0;
        end else begin
            sk = m_s2; m_s2 = m_s1; m_s1 = raw_k;
            ss = m_t2; m_t2 = m_t1; m_t1 = raw_start;

            if (sk == kval) krun++;
            else begin kval = sk; krun = 1; end
            exp_k = 4'b0;
            if (armed) begin
                if (onehot(sk) && krun == DEB) begin
                    exp_k = sk;
                    armed = 1'b0;
                    blind = 1'b1;
                end
            end else if (blind) begin
                blind = 1'b0;
                zrun  = 0;
            end else begin
                zrun = (sk == 4'b0) ? zrun + 1 : 0;
                if (zrun == DEB) armed = 1'b1;
            end
            exp_busy = !armed || onehot(sk);

            if (ss == sval) srun++;
            else begin sval = ss; srun = 1; end
            exp_start = 1'b0;
            if (ss != lvl && srun == DEB) begin
                lvl = ss;
                exp_start = ss;
            end
        end
    end

    // Compare process plus event bookkeeping used by the directed checks.
    int         k_pulses = 0, last_k_cyc = -1;
    logic [3:0] last_k_val = 4'b0;
    int         start_pulses = 0, last_start_cyc = -1;
    int         busy_cnt = 0, last_busy_fall = -1;
    logic       prev_busy = 1'b0;

    always @(negedge clock) begin
        check("k", 32'(k), 32'(exp_k));
        check("start", 32'(start), 32'(exp_start));
        check("busy", 32'(busy), 32'(exp_busy));
        if (k != 4'b0) begin
            k_pulses++;
            last_k_cyc = cyc;
            last_k_val = k;
        end
        if (start) begin
            start_pulses++;
            last_start_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (prev_busy && !busy) last_busy_fall = cyc;
        prev_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    initial begin
        int e, ek, es, base, base_s, bb, hold, r;

        reset = 1'b1;
        tick(3);
        check("reset_k", 32'(k), 32'h0);
        check("reset_start", 32'(start), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick(4);

        // Stable press of key 1, held long: one pulse DEB+1 cycles after the first sampling edge.
        base = k_pulses;
        raw_k = 4'b0010;
        e = cyc + 1;
        tick(56);
        check("press_pulses", 32'(k_pulses - base), 32'd1);
        check("press_cycle", 32'(last_k_cyc), 32'(e + DEB + 1));
        check("press_code", 32'(last_k_val), 32'b0010);
        raw_k = 4'b0;
        tick(12);
        check("release_idle", 32'(busy), 32'h0);

        // Bouncing press, then stable.
        base = k_pulses;
        for (int i = 0; i < 8; i++) begin
            raw_k = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(1);
        end
        raw_k = 4'b0010;
        e = cyc + 1;
        tick(20);
        check("bounce_pulses", 32'(k_pulses - base), 32'd1);
        check("bounce_cycle", 32'(last_k_cyc), 32'(e + DEB + 1));
        raw_k = 4'b0;
        tick(12);

        // Two keys together never fire and never leave IDLE.
        base = k_pulses;
        bb = busy_cnt;
        raw_k = 4'b0101;
        tick(20);
        check("multi_pulses", 32'(k_pulses - base), 32'd0);
        check("multi_busy", 32'(busy_cnt - bb), 32'd0);
        raw_k = 4'b0;
        tick(6);

        // Key 3 release with a two-sample glitch after two zero samples.
        raw_k = 4'b1000;
        tick(12);
        base = k_pulses;
        raw_k = 4'b0;
        e = cyc + 1;
        tick(2);
        raw_k = 4'b1000;
        tick(2);
        raw_k = 4'b0;
        tick(15);
        check("glitch_no_pulse", 32'(k_pulses - base), 32'd0);
        check("glitch_idle_cycle", 32'(last_busy_fall), 32'(e + 9));
        base = k_pulses;
        raw_k = 4'b0001;
        e = cyc + 1;
        tick(12);
        check("key0_pulses", 32'(k_pulses - base), 32'd1);
        check("key0_code", 32'(last_k_val), 32'b0001);
        check("key0_cycle", 32'(last_k_cyc), 32'(e + DEB + 1));
        raw_k = 4'b0;
        tick(12);

        // Start held while key 1 is pressed; the two channels time independently.
        base = k_pulses;
        base_s = start_pulses;
        raw_k = 4'b0010;
        ek = cyc + 1;
        tick(3);
        raw_start = 1'b1;
        es = cyc + 1;
        tick(10);
        raw_start = 1'b0;
        tick(10);
        raw_k = 4'b0;
        tick(12);
        check("both_k_pulses", 32'(k_pulses - base), 32'd1);
        check("both_start_pulses", 32'(start_pulses - base_s), 32'd1);
        check("both_k_cycle", 32'(last_k_cyc), 32'(ek + DEB + 1));
        check("both_start_cycle", 32'(last_start_cyc), 32'(es + DEB + 1));

        // Reset while debouncing with cnt=3: no pulse where it would have fired, fresh press after.
        base = k_pulses;
        raw_k = 4'b0100;
        e = cyc + 1;
        tick(5);
        check("deb_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        tick(1);
        check("postreset_k", 32'(k), 32'h0);
        check("postreset_start", 32'(start), 32'h0);
        check("postreset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick(20);
        check("postreset_pulses", 32'(k_pulses - base), 32'd1);
        check("postreset_cycle", 32'(last_k_cyc), 32'(e + 11));
        raw_k = 4'b0;
        tick(12);

        // Random bouncing keys, start and occasional resets, checked by the model each cycle.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) raw_k = 4'b0;
            else if (r < 8) raw_k = 4'(1 << $urandom_range(0, 3));
            else raw_k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) raw_start = ~raw_start;
            hold = int'($urandom_range(1, 8));
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            tick(hold);
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4: number of consecutive stable synchronized samples needed to accept a press or a release; legal range 1..255.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 raw_k  input  4  asynchronous, bouncing colour keys; bit n is key n; 1 = pressed.
REQ-005 raw_start  input  1  asynchronous, bouncing start button; 1 = pressed.
REQ-006 k  output  4  registered one-hot key event; one cycle per accepted press; goes to the game core's k input.
REQ-007 start  output  1  registered one-cycle start event; goes to the game core's start input.
REQ-008 busy  output  1  registered; 1 whenever the key FSM is not in IDLE.

Function
REQ-009 raw_k and raw_start SHALL each pass through a two-flop synchronizer (sync_k, sync_s) before any other logic uses them.
REQ-010 The key FSM SHALL have five states: IDLE, DEBOUNCE, FIRE, WAIT_REL, REL_DEB.
REQ-011 IDLE: if sync_k is one-hot, latch it into code, set cnt=1, go to DEBOUNCE (or to FIRE when DEB_CYCLES=1); on zero or multi-hot, stay in IDLE.
REQ-012 DEBOUNCE: if sync_k==code, increment cnt and go to FIRE when cnt reaches DEB_CYCLES; if sync_k is a different one-hot, latch the new code and set cnt=1; on zero or multi-hot, return to IDLE.
REQ-013 FIRE: drive k=code for exactly one cycle, then go to WAIT_REL; in every other state k=0.
REQ-014 Press latency: raw_k held stable from edge E gives k=1 during the cycle after edge E+DEB_CYCLES+1 (6 cycles for the default).
REQ-015 WAIT_REL: stay while sync_k!=0; when sync_k==0, set cnt=1 and go to REL_DEB (or to IDLE when DEB_CYCLES=1).
REQ-016 REL_DEB: each cycle with sync_k==0, increment cnt and go to IDLE at DEB_CYCLES; any nonzero sync_k returns to WAIT_REL.
REQ-017 A held key SHALL produce exactly one k pulse however long it is held; a second pulse requires a debounced release.
REQ-018 Multi-key presses (two or more bits set) SHALL never produce a k pulse.
REQ-019 The start channel SHALL be independent of the key FSM: an 8-bit counter debounces sync_s into a stable level start_lvl using the same DEB_CYCLES rule in both directions.
REQ-020 start SHALL pulse for one cycle on each 0->1 transition of start_lvl; key and start events may occur in the same cycle.
REQ-021 Counters SHALL be 8 bits and SHALL never wrap; they are compared for equality with DEB_CYCLES.
REQ-022 busy=0 exactly when the key FSM is in IDLE.

Reset
REQ-023 When reset=1 at a rising edge: clear synchronizers, cnt, code, start counter and start_lvl; put the FSM in IDLE; drive k=0, start=0, busy=0.
REQ-024 Reset SHALL win over every event in the same cycle, including reset in the middle of DEBOUNCE or FIRE; no pulse is emitted afterwards until a full new press has been debounced.
REQ-025 The first active edge after reset deasserts SHALL sample raw inputs normally; no extra dead cycles.

Verification
REQ-026 DEB_CYCLES=4; raw_k=4'b0010 stable from edge 10 -> k=4'b0010 for exactly one cycle after edge 15; held 50 more cycles -> no further pulse.
REQ-027 raw_k bounces 0010/0000 on alternate cycles for 8 cycles, then holds 0010 -> a single pulse 6 cycles after the bouncing stops.
REQ-028 raw_k=4'b0101 held 20 cycles -> k stays 0; busy stays 0.
REQ-029 Press key 3, release with a 2-cycle glitch back to 1000 after 2 zero samples, then hold 0 -> no pulse during the glitch; IDLE reached 4 zero samples after the glitch; the next press of key 0 pulses 4'b0001.
REQ-030 raw_start held high 10 cycles while key 1 is pressed -> start and k each pulse once; their timing is independent.
REQ-031 reset=1 for one cycle while the FSM is in DEBOUNCE with cnt=3 -> k stays 0 at the cycle where it would have fired; outputs are 0 in the cycle after reset.
